// File: rtl/keccak_squeeze.sv
// keccak_squeeze: streams the rate portion of the sponge state out as W-bit
// words over a valid/ready interface. When more than one rate block of output
// is needed, it requests one zero-message core permutation for each further
// block.
//
// Parameters: R rate width (multiple of W), W word width, LENW length width.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start, out_len  begin a squeeze of out_len words (out_len==0 is ignored)
//   rate_in         rate portion of the sponge state, word 0 in the MSBs
//   perm_req        one-cycle request for one permutation
//   perm_done       core has updated its state
//   out_valid/out_ready/out_data/out_last  output word stream
//   busy            high whenever not idle
// Optional build macro: KECCAK_SQUEEZE_BSWAP_EN byte-reverses each out_data
// word into FIPS 202 lane byte order. Timing and control are unaffected.
//
// state  | meaning
// IDLE   | waiting for start with a non-zero length
// LOAD   | capturing rate_in into the word buffer
// STREAM | presenting buffer words to the consumer
// PERM   | waiting for the core to finish a zero-message permutation
module keccak_squeeze #(
  parameter int R    = 1088,
  parameter int W    = 64,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [LENW-1:0] out_len,
  input  logic [R-1:0]    rate_in,
  output logic            perm_req,
  input  logic            perm_done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic            busy
);

  localparam int K  = R / W;
  localparam int IW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, PERM} state_t;

  state_t          state;
  logic [R-1:0]    buffer;
  logic [IW-1:0]   idx;
  logic [LENW-1:0] remaining;
  logic [W-1:0]    word;

  // The buffer shifts left by one word per handshake, so the current word is
  // always the top slice; this keeps out_data straight off flops.
  assign word = buffer[R-1 -: W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      buffer    <= '0;
      idx       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      perm_req  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (out_len != '0)) begin
            remaining <= out_len;
            state     <= LOAD;
          end
        end
        LOAD: begin
          buffer    <= rate_in;
          idx       <= '0;
          out_valid <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (out_ready) begin
            remaining <= remaining - LENW'(1);
            idx       <= idx + IW'(1);
            buffer    <= buffer << W;
            // Finishing the requested length takes priority over a block end.
            if (remaining == LENW'(1)) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end else if (idx == IW'(K - 1)) begin
              out_valid <= 1'b0;
              perm_req  <= 1'b1;
              state     <= PERM;
            end
          end
        end
        PERM: begin
          perm_req <= 1'b0;
          // perm_done coinciding with the request cycle is accepted.
          if (perm_done) state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_last = out_valid && (remaining == LENW'(1));
  assign busy     = (state != IDLE);

`ifdef KECCAK_SQUEEZE_BSWAP_EN
  always_comb begin
    out_data = '0;
    for (int b = 0; b < W / 8; b++) out_data[8*b +: 8] = word[W-1-8*b -: 8];
  end
`else
  assign out_data = word;
`endif

endmodule

// File: tb/tb_keccak_squeeze.sv
module tb_keccak_squeeze;

  localparam int R    = 1088;
  localparam int W    = 64;
  localparam int LENW = 16;
  localparam int K    = R / W;

  logic            clk;
  logic            reset;
  logic            start;
  logic [LENW-1:0] out_len;
  logic [R-1:0]    rate_in;
  logic            perm_req;
  logic            perm_done;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic            busy;

  keccak_squeeze #(.R(R), .W(W), .LENW(LENW)) dut (
    .clk(clk), .reset(reset), .start(start), .out_len(out_len),
    .rate_in(rate_in), .perm_req(perm_req), .perm_done(perm_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  exp_t         q[$];
  logic [R-1:0] blk[8];
  int           errors = 0;
  int           checks = 0;
  int           perm_cnt = 0;
  int           base_perm = 0;
  int           pr_cnt = 0;
  int           hs_cnt = 0;
  int           inj_req = 0;
  int           inj_ack = 0;
  int           ready_mode = 0;

  // Core model: each permutation moves the state on to the next block.
  assign rate_in = blk[(perm_cnt - base_perm) & 7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input logic [R-1:0] b, input int k);
    logic [W-1:0] w, s;
    w = W'(b >> ((K - 1 - k) * W));
    s = w;
`ifdef KECCAK_SQUEEZE_BSWAP_EN
    for (int i = 0; i < W / 8; i++) s[8*i +: 8] = w[W-1-8*i -: 8];
`endif
    return s;
  endfunction

  function automatic logic [R-1:0] rand_block();
    logic [R-1:0] v;
    v = '0;
    for (int i = 0; i < R / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Core responder: answers perm_req after 0..2 cycles; can also inject a
  // stray perm_done on request.
  initial begin
    perm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (perm_req) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        perm_cnt++;
        perm_done = 1'b1;
        @(negedge clk);
        perm_done = 1'b0;
      end else if (inj_ack != inj_req) begin
        inj_ack   = inj_req;
        perm_done = 1'b1;
        @(negedge clk);
        perm_done = 1'b0;
      end
    end
  end

  // Consumer ready pattern: 0 always ready, 1 repeating 1,0,0,1, 2 random.
  initial begin
    int cyc;
    logic [3:0] pat;
    pat = 4'b1001;
    cyc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 4];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit           prev_stall;
    logic [W-1:0] prev_data;
    exp_t         e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (perm_req) pr_cnt++;
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_word", out_data, 0);
            errors += (out_data == '0) ? 1 : 0;
          end else begin
            e = q.pop_front();
            chk("word_data", out_data, e.d);
            chk("word_last", out_last, e.l);
          end
          hs_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic start_squeeze(input int n);
    exp_t e;
    base_perm = perm_cnt;
    for (int i = 0; i < n; i++) begin
      e.d = exp_word(blk[i / K], i % K);
      e.l = (i == n - 1);
      q.push_back(e);
    end
    @(posedge clk); #1;
    start   = 1'b1;
    out_len = LENW'(n);
    @(posedge clk); #1;
    start   = 1'b0;
    out_len = LENW'($urandom());
    chk("busy_in_load", busy, 1);
    chk("valid_in_load", out_valid, 0);
    @(posedge clk); #1;
    chk("valid_after_load", out_valid, 1);
  endtask

  task automatic run(input int n, input int mode, input bit inject);
    int nblk, cycles, pr0;
    nblk = (n + K - 1) / K;
    ready_mode = mode;
    pr0 = pr_cnt;
    start_squeeze(n);
    cycles = 0;
    while (busy && cycles < 3000) begin
      if (inject && cycles == 2) begin
        start   = 1'b1;
        out_len = 16'd3;
        inj_req++;
      end else if (inject && cycles == 3) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    chk("done_in_time", cycles < 3000, 1);
    if (mode == 0 && nblk == 1) chk("one_per_clock", cycles, n);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_after", busy, 0);
    chk("valid_after", out_valid, 0);
    chk("queue_empty", q.size(), 0);
    chk("perm_count", perm_cnt - base_perm, nblk - 1);
    chk("perm_req_cycles", pr_cnt - pr0, nblk - 1);
  endtask

  initial begin
    int c, hs0;
    reset   = 1'b0;
    start   = 1'b1;
    out_len = 16'd7;
    for (int i = 0; i < 8; i++) blk[i] = '0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_perm_req", perm_req, 0);
      chk("rst_busy", busy, 0);
    end
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_release", busy, 0);

    // Single block with word k = k.
    for (int k = 0; k < K; k++) blk[0][R-1-k*W -: W] = W'(k);
    run(4, 0, 1'b0);

    // Multi-block, backpressure, random and boundary lengths.
    for (int i = 0; i < 8; i++) blk[i] = rand_block();
    run(20, 0, 1'b0);
    for (int i = 0; i < 8; i++) blk[i] = rand_block();
    run(10, 1, 1'b0);
    for (int i = 0; i < 8; i++) blk[i] = rand_block();
    run(40, 2, 1'b0);
    for (int i = 0; i < 8; i++) blk[i] = rand_block();
    run(K, 0, 1'b0);
    run(1, 1, 1'b0);
    for (int i = 0; i < 8; i++) blk[i] = rand_block();
    run(2 * K, 2, 1'b0);

    // start with a zero length is ignored.
    @(posedge clk); #1;
    start   = 1'b1;
    out_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("zero_len_busy", busy, 0);
    chk("zero_len_valid", out_valid, 0);

    // start and perm_done during STREAM are ignored.
    for (int i = 0; i < 8; i++) blk[i] = rand_block();
    run(12, 0, 1'b1);

    // Reset after five words of twenty.
    for (int i = 0; i < 8; i++) blk[i] = rand_block();
    ready_mode = 0;
    hs0 = hs_cnt;
    start_squeeze(20);
    c = 0;
    while (hs_cnt - hs0 < 5 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reached_word5", hs_cnt - hs0, 5);
    chk("valid_before_reset", out_valid, 1);
    reset = 1'b0;
    #1;
    chk("async_valid_drop", out_valid, 0);
    chk("async_busy_drop", busy, 0);
    chk("async_perm_req", perm_req, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) blk[i] = rand_block();
    run(2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
